hi_lo_mdu_ctrl: RTL and testbench

//  Sequencer and owner of the HI/LO register pair for the EXE stage.

---
 rtl/hi_lo_mdu_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_hi_lo_mdu_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hi_lo_mdu_ctrl.sv
// HI/LO register owner for the EXE stage: sequences a pipelined multiplier
// and a radix-2 restoring divider, and holds EXE until the result has committed.
module hi_lo_mdu_ctrl #(
   parameter int          MUL_STAGES = 2,
   parameter logic [31:0] HILO_RESET = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [7:0]  hi_lo_op,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   input  logic        op_fire,
   input  logic        wr_disable,
   input  logic        flush,
   output logic        hi_lo_ready,
   output logic [31:0] hi_lo_result,
   output logic        busy,
   output logic [31:0] hi_q,
   output logic [31:0] lo_q
);

   localparam int OP_MULT  = 0;
   localparam int OP_MULTU = 1;
   localparam int OP_DIV   = 2;
   localparam int OP_DIVU  = 3;
   localparam int OP_MFHI  = 4;
   localparam int OP_MFLO  = 5;
   localparam int OP_MTHI  = 6;
   localparam int OP_MTLO  = 7;

   localparam logic [5:0] MUL_CNT_INIT = 6'(MUL_STAGES - 1);

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [32:0] mul_a_q, mul_a_d;
   logic [32:0] mul_b_q, mul_b_d;
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] rem_q, rem_d;
   logic        neg_q, neg_d;
   logic        rsign_q, rsign_d;
   logic [31:0] hi_d, lo_d;

   logic        is_mul, is_div, is_signed, abort;
   logic [63:0] prod_full, mul_res;
   logic [32:0] div_tmp;
   logic        div_ge;
   logic [31:0] div_sub, quo_fix, rem_fix;

   assign is_mul    = hi_lo_op[OP_MULT] | hi_lo_op[OP_MULTU];
   assign is_div    = hi_lo_op[OP_DIV]  | hi_lo_op[OP_DIVU];
   assign is_signed = hi_lo_op[OP_MULT] | hi_lo_op[OP_DIV];
   assign abort     = flush | ~op_valid;

   // Operand registers form the first multiplier stage; the product itself
   // passes through MUL_STAGES-1 further registers and commits from the last one.
   assign prod_full = 64'($signed(mul_a_q)) * 64'($signed(mul_b_q));

   generate
      if (MUL_STAGES == 1) begin : g_no_pipe
         assign mul_res = prod_full;
      end else begin : g_pipe
         logic [63:0] stage_q [MUL_STAGES-1];
         logic [63:0] stage_d [MUL_STAGES-1];
         for (genvar gi = 0; gi < MUL_STAGES - 1; gi++) begin : g_stage
            if (gi == 0) begin : g_first
               assign stage_d[gi] = prod_full;
            end else begin : g_next
               assign stage_d[gi] = stage_q[gi-1];
            end
            always_ff @(posedge clk or posedge reset) begin
               if (reset) stage_q[gi] <= 64'h0;
               else       stage_q[gi] <= stage_d[gi];
            end
         end
         assign mul_res = stage_q[MUL_STAGES-2];
      end
   endgenerate

   assign div_tmp = {rem_q, quo_q[31]};
   assign div_ge  = div_tmp >= {1'b0, dvs_q};
   assign div_sub = div_tmp[31:0] - dvs_q;
   assign quo_fix = neg_q   ? -quo_q : quo_q;
   assign rem_fix = rsign_q ? -rem_q : rem_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 6'd0;
         mul_a_q <= 33'd0;
         mul_b_q <= 33'd0;
         dvs_q   <= 32'd0;
         quo_q   <= 32'd0;
         rem_q   <= 32'd0;
         neg_q   <= 1'b0;
         rsign_q <= 1'b0;
         hi_q    <= HILO_RESET;
         lo_q    <= HILO_RESET;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mul_a_q <= mul_a_d;
         mul_b_q <= mul_b_d;
         dvs_q   <= dvs_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         neg_q   <= neg_d;
         rsign_q <= rsign_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (op_valid && !flush) begin
               if (is_mul)      state_d = S_MUL;
               else if (is_div) state_d = S_DIV;
            end
         end
         S_MUL:  if (abort) state_d = S_IDLE; else if (cnt_q == 6'd0) state_d = S_DONE;
         S_DIV:  if (abort) state_d = S_IDLE; else if (cnt_q == 6'd0) state_d = S_FIX;
         S_FIX:  state_d = abort ? S_IDLE : S_DONE;
         S_DONE: if (op_fire || abort) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d   = cnt_q;
      mul_a_d = mul_a_q;
      mul_b_d = mul_b_q;
      dvs_d   = dvs_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      neg_d   = neg_q;
      rsign_d = rsign_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: begin
            if (op_valid && !flush && is_mul) begin
               cnt_d   = MUL_CNT_INIT;
               mul_a_d = {is_signed & src1[31], src1};
               mul_b_d = {is_signed & src2[31], src2};
            end else if (op_valid && !flush && is_div) begin
               cnt_d   = 6'd31;
               quo_d   = (is_signed && src1[31]) ? -src1 : src1;
               dvs_d   = (is_signed && src2[31]) ? -src2 : src2;
               rem_d   = 32'd0;
               neg_d   = is_signed & (src1[31] ^ src2[31]);
               rsign_d = is_signed & src1[31];
            end
            if (op_valid && op_fire && !wr_disable && !flush) begin
               if (hi_lo_op[OP_MTHI]) hi_d = src1;
               if (hi_lo_op[OP_MTLO]) lo_d = src1;
            end
         end
         S_MUL: cnt_d = cnt_q - 6'd1;
         S_DIV: begin
            cnt_d = cnt_q - 6'd1;
            rem_d = div_ge ? div_sub : div_tmp[31:0];
            quo_d = {quo_q[30:0], div_ge};
         end
         default: ;
      endcase
      // Commit happens only on the edge that actually enters DONE, so abort wins.
      if (state_d == S_DONE && state_q != S_DONE && !wr_disable) begin
         if (state_q == S_MUL) begin
            hi_d = mul_res[63:32];
            lo_d = mul_res[31:0];
         end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
         end
      end
   end

   always_comb begin
      hi_lo_ready  = 1'b0;
      hi_lo_result = 32'd0;
      busy         = (state_q != S_IDLE);
      if (state_q == S_IDLE)
         hi_lo_ready = op_valid & (|hi_lo_op[OP_MTLO:OP_MFHI]);
      else if (state_q == S_DONE)
         hi_lo_ready = 1'b1;
      if (hi_lo_op[OP_MFHI])      hi_lo_result = hi_q;
      else if (hi_lo_op[OP_MFLO]) hi_lo_result = lo_q;
   end

endmodule

// File: tb/tb_hi_lo_mdu_ctrl.sv
// Directed bench for hi_lo_mdu_ctrl with hand-computed HI/LO values and cycle latencies.
module tb_hi_lo_mdu_ctrl;

   localparam logic [7:0] MULT  = 8'h01;
   localparam logic [7:0] MULTU = 8'h02;
   localparam logic [7:0] DIV   = 8'h04;
   localparam logic [7:0] DIVU  = 8'h08;
   localparam logic [7:0] MFHI  = 8'h10;
   localparam logic [7:0] MFLO  = 8'h20;
   localparam logic [7:0] MTHI  = 8'h40;
   localparam logic [7:0] MTLO  = 8'h80;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic [7:0]  hi_lo_op;
   logic [31:0] src1, src2;
   logic        op_fire, wr_disable, flush;
   logic        hi_lo_ready, busy;
   logic [31:0] hi_lo_result, hi_q, lo_q;

   int n_assert = 0;
   int n_fail   = 0;

   hi_lo_mdu_ctrl #(.MUL_STAGES(2), .HILO_RESET(32'h0)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .hi_lo_op(hi_lo_op),
      .src1(src1), .src2(src2), .op_fire(op_fire), .wr_disable(wr_disable),
      .flush(flush), .hi_lo_ready(hi_lo_ready), .hi_lo_result(hi_lo_result),
      .busy(busy), .hi_q(hi_q), .lo_q(lo_q)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      op_valid = 1'b0; hi_lo_op = 8'h0; src1 = 32'h0; src2 = 32'h0;
      op_fire = 1'b0; wr_disable = 1'b0; flush = 1'b0;
   endtask

   task automatic start(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
      op_valid = 1'b1; hi_lo_op = op; src1 = a; src2 = b;
      op_fire = 1'b0; wr_disable = 1'b0; flush = 1'b0;
   endtask

   task automatic retire(input string tag);
      op_fire = 1'b1;
      cyc();
      idle();
      #1;
      check(tag, 32'(busy), 32'd0);
   endtask

   initial begin
      idle();
      reset = 1'b1;
      repeat (3) cyc();
      check("rst_busy",   32'(busy), 32'd0);
      check("rst_ready",  32'(hi_lo_ready), 32'd0);
      check("rst_result", hi_lo_result, 32'd0);
      check("rst_hi", hi_q, 32'd0);
      check("rst_lo", lo_q, 32'd0);
      reset = 1'b0;

      // MULT -2 * 3: ready exactly three cycles after the first valid cycle
      cyc(); start(MULT, 32'hFFFF_FFFE, 32'd3); #1;
      check("mult_t0_ready", 32'(hi_lo_ready), 32'd0);
      for (int k = 1; k <= 2; k++) begin
         cyc(); #1;
         check("mult_wait_ready", 32'(hi_lo_ready), 32'd0);
         check("mult_wait_busy", 32'(busy), 32'd1);
      end
      cyc(); #1;
      check("mult_ready", 32'(hi_lo_ready), 32'd1);
      check("mult_hi", hi_q, 32'hFFFF_FFFF);
      check("mult_lo", lo_q, 32'hFFFF_FFFA);
      retire("mult_back_idle");

      cyc(); start(MFHI, 32'h0, 32'h0); #1;
      check("mfhi_ready", 32'(hi_lo_ready), 32'd1);
      check("mfhi_result", hi_lo_result, 32'hFFFF_FFFF);
      hi_lo_op = MFLO; #1;
      check("mflo_result", hi_lo_result, 32'hFFFF_FFFA);
      cyc(); idle();

      // DIV -7 / 2 -> quotient -3, remainder -1, ready at T+34
      cyc(); start(DIV, 32'hFFFF_FFF9, 32'd2); #1;
      check("div_t0_ready", 32'(hi_lo_ready), 32'd0);
      for (int k = 1; k <= 33; k++) begin
         cyc(); #1;
         check("div_wait_ready", 32'(hi_lo_ready), 32'd0);
      end
      cyc(); #1;
      check("div_ready", 32'(hi_lo_ready), 32'd1);
      check("div_lo", lo_q, 32'hFFFF_FFFD);
      check("div_hi", hi_q, 32'hFFFF_FFFF);
      retire("div_back_idle");

      cyc(); start(DIVU, 32'd7, 32'd0);
      repeat (34) cyc();
      #1;
      check("divu0_ready", 32'(hi_lo_ready), 32'd1);
      check("divu0_lo", lo_q, 32'hFFFF_FFFF);
      check("divu0_hi", hi_q, 32'd7);
      retire("divu0_back_idle");

      // MT writes, MF reads the committed value the very next cycle
      cyc(); start(MTHI, 32'h1234, 32'h0); op_fire = 1'b1; #1;
      check("mthi_ready", 32'(hi_lo_ready), 32'd1);
      cyc(); hi_lo_op = MFHI; src1 = 32'h0; #1;
      check("mfhi2_ready", 32'(hi_lo_ready), 32'd1);
      check("mfhi2_result", hi_lo_result, 32'h1234);
      cyc(); hi_lo_op = MTLO; src1 = 32'h5678; wr_disable = 1'b1;
      cyc(); hi_lo_op = MFLO; src1 = 32'h0; wr_disable = 1'b0; #1;
      check("mtlo_wrdis_lo", hi_lo_result, 32'hFFFF_FFFF);
      cyc(); hi_lo_op = MTLO; src1 = 32'h5678;
      cyc(); hi_lo_op = MFLO; src1 = 32'h0; #1;
      check("mtlo_lo", hi_lo_result, 32'h5678);
      cyc(); hi_lo_op = 8'h0; op_fire = 1'b0; #1;
      check("noop_ready", 32'(hi_lo_ready), 32'd0);
      check("noop_result", hi_lo_result, 32'd0);
      cyc(); idle();

      // DIVU flushed at T+10: back to IDLE at T+11, no write
      cyc(); start(DIVU, 32'd100, 32'd3);
      repeat (10) cyc();
      flush = 1'b1; #1;
      check("flush_busy_before", 32'(busy), 32'd1);
      cyc(); idle(); #1;
      check("flush_busy_after", 32'(busy), 32'd0);
      check("flush_hi", hi_q, 32'h1234);
      check("flush_lo", lo_q, 32'h5678);

      // flush on the completion cycle beats the commit
      cyc(); start(MULT, 32'd7, 32'd7);
      cyc();
      cyc(); flush = 1'b1;
      cyc(); idle(); #1;
      check("flush_win_busy", 32'(busy), 32'd0);
      check("flush_win_lo", lo_q, 32'h5678);

      // MULTU 5*6 with wr_disable on the completion cycle
      cyc(); start(MULTU, 32'd5, 32'd6);
      cyc();
      cyc(); wr_disable = 1'b1;
      cyc(); wr_disable = 1'b0; #1;
      check("wrdis_ready", 32'(hi_lo_ready), 32'd1);
      check("wrdis_hi", hi_q, 32'h1234);
      check("wrdis_lo", lo_q, 32'h5678);
      retire("wrdis_back_idle");

      cyc(); start(MULTU, 32'd5, 32'd6);
      cyc();
      cyc(); #1;
      check("multu_early_ready", 32'(hi_lo_ready), 32'd0);
      cyc(); #1;
      check("multu_hi", hi_q, 32'd0);
      check("multu_lo", lo_q, 32'd30);
      retire("multu_back_idle");

      cyc(); start(MULTU, 32'hFFFF_FFFE, 32'd3);
      repeat (3) cyc();
      #1;
      check("multu_big_hi", hi_q, 32'd2);
      check("multu_big_lo", lo_q, 32'hFFFF_FFFA);
      retire("multu_big_back_idle");

      // asynchronous reset in the middle of a division
      cyc(); start(DIV, 32'd100, 32'd7);
      repeat (5) cyc();
      #2; reset = 1'b1; #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_hi", hi_q, 32'd0);
      check("arst_lo", lo_q, 32'd0);
      idle();
      cyc(); reset = 1'b0;
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
